// File: rtl/usb_tx_pkg.sv
// -----------------------------------------------------------------------------
// usb_tx_pkg
// Shared types and constants for the USB full-speed transmit path.
//   tx_state_t   : serializer state encoding
//   SYNC_BYTE    : default sync pattern, sent LSB-first (0000_0001 on the wire)
//   STUFF_LIMIT  : default run of 1s after which a stuff 0 is inserted
//   EOP_BITS     : number of SE0 bit periods in an end-of-packet
// -----------------------------------------------------------------------------
package usb_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      EOP,
      POST
   } tx_state_t;

   localparam int unsigned DEF_CLKS_PER_BIT = 8;
   localparam logic [7:0]  SYNC_BYTE        = 8'h80;
   localparam int unsigned STUFF_LIMIT      = 6;
   localparam int unsigned EOP_BITS         = 2;

endpackage

// File: rtl/usb_tx_serializer_if.sv
// -----------------------------------------------------------------------------
// usb_tx_serializer_if
// Byte handshake between a packet source and the TX serializer.
//   tx_data  : packet byte
//   tx_valid : tx_data/tx_last valid
//   tx_last  : current byte is the final byte of the packet
//   tx_ready : byte consumed on a cycle where tx_valid && tx_ready
// master = byte source, slave = serializer.
// -----------------------------------------------------------------------------
interface usb_tx_serializer_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      output tx_last,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      input  tx_last,
      output tx_ready
   );

endinterface

// File: rtl/bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Bit-period divider shared by the USB TX and RX paths.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   enable  : count while high; counter is held at 0 while low
//   clk_cnt : position within the bit period, 0..CLKS_PER_BIT-1
//   strobe  : high on the last clock of each bit period while enabled
// -----------------------------------------------------------------------------
module bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   output logic [CNT_W-1:0] clk_cnt,
   output logic             strobe
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         clk_cnt <= '0;
      end else if (clk_cnt == LAST_CNT) begin
         clk_cnt <= '0;
      end else begin
         clk_cnt <= clk_cnt + 1'b1;
      end
   end

   assign strobe = enable && (clk_cnt == LAST_CNT);

endmodule

// File: rtl/usb_tx_serializer.sv
// -----------------------------------------------------------------------------
// usb_tx_serializer
// Byte-to-bit stage of the USB full-speed transmitter, feeding the NRZI encoder.
// Prepends SYNC, shifts bytes out LSB-first with bit stuffing, then sends a
// two-bit EOP followed by one idle bit.
//   clk          : system clock
//   rst          : synchronous active-high reset (aborts a packet, no EOP)
//   tx           : byte handshake (tx_data, tx_valid, tx_last, tx_ready)
//   d_orig       : unencoded bit, stable for the whole bit period
//   shift_enable : strobe on the last clock of each bit period
//   eop          : drive SE0
//   sending      : SYNC/DATA/EOP in progress; low means idle J
//   busy         : high from packet start through the post-EOP idle bit
//   tx_underrun  : pulse when a byte was needed but tx_valid was low
// -----------------------------------------------------------------------------
module usb_tx_serializer
   import usb_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = usb_tx_pkg::DEF_CLKS_PER_BIT,
   parameter logic [7:0]  SYNC_BYTE    = usb_tx_pkg::SYNC_BYTE,
   parameter int unsigned STUFF_LIMIT  = usb_tx_pkg::STUFF_LIMIT
) (
   input  logic          clk,
   input  logic          rst,
   usb_tx_serializer_if.slave tx,
   output logic          d_orig,
   output logic          shift_enable,
   output logic          eop,
   output logic          sending,
   output logic          busy,
   output logic          tx_underrun
);

   localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [2:0]  STUFF_AT = 3'(STUFF_LIMIT);
   localparam logic [1:0]  EOP_LAST = 2'(EOP_BITS - 1);

   tx_state_t  state, state_nx;
   logic [7:0] shreg, shreg_nx;
   logic [2:0] bit_idx, bit_idx_nx;
   logic [2:0] ones_cnt, ones_nx;
   logic [2:0] ones_inc;
   logic       stuff, stuff_nx;
   logic       last_byte, last_nx;
   logic [1:0] eop_cnt, eop_cnt_nx;
   logic       advance;
   logic       tx_ready_c;

   logic [CNT_W-1:0] clk_cnt;
   logic             strobe;

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CNT_W        (CNT_W)
   ) u_bit_timer (
      .clk     (clk),
      .rst     (rst),
      .enable  (state != IDLE),
      .clk_cnt (clk_cnt),
      .strobe  (strobe)
   );

   assign shift_enable = strobe;
   assign busy         = (state != IDLE);
   assign ones_inc     = ones_cnt + 3'd1;
   assign tx.tx_ready  = tx_ready_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shreg     <= SYNC_BYTE;
         bit_idx   <= '0;
         ones_cnt  <= '0;
         stuff     <= 1'b0;
         last_byte <= 1'b0;
         eop_cnt   <= '0;
      end else begin
         state     <= state_nx;
         shreg     <= shreg_nx;
         bit_idx   <= bit_idx_nx;
         ones_cnt  <= ones_nx;
         stuff     <= stuff_nx;
         last_byte <= last_nx;
         eop_cnt   <= eop_cnt_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      shreg_nx    = shreg;
      bit_idx_nx  = bit_idx;
      ones_nx     = ones_cnt;
      stuff_nx    = stuff;
      last_nx     = last_byte;
      eop_cnt_nx  = eop_cnt;
      advance     = 1'b0;
      tx_ready_c  = 1'b0;
      tx_underrun = 1'b0;
      d_orig      = 1'b1;
      eop         = 1'b0;
      sending     = 1'b0;

      case (state)
         IDLE: begin
            // Preload SYNC so its bit 0 is on d_orig from the first SYNC clock.
            shreg_nx   = SYNC_BYTE;
            bit_idx_nx = '0;
            ones_nx    = '0;
            stuff_nx   = 1'b0;
            last_nx    = 1'b0;
            eop_cnt_nx = '0;
            if (tx.tx_valid) begin
               state_nx = SYNC;
            end
         end

         SYNC, DATA: begin
            sending = 1'b1;
            d_orig  = stuff ? 1'b0 : shreg[0];
            if (strobe) begin
               // A stuff period holds the payload: the bit that triggered it is
               // only retired (shifted out) on the stuff bit's own strobe.
               if (stuff) begin
                  ones_nx  = '0;
                  stuff_nx = 1'b0;
                  advance  = 1'b1;
               end else if (shreg[0]) begin
                  ones_nx = ones_inc;
                  if (ones_inc == STUFF_AT) begin
                     stuff_nx = 1'b1;
                  end else begin
                     advance = 1'b1;
                  end
               end else begin
                  ones_nx = '0;
                  advance = 1'b1;
               end

               if (advance) begin
                  if (bit_idx == 3'd7) begin
                     if ((state == SYNC) || !last_byte) begin
                        if (tx.tx_valid) begin
                           tx_ready_c = 1'b1;
                           shreg_nx   = tx.tx_data;
                           last_nx    = tx.tx_last;
                           bit_idx_nx = '0;
                           state_nx   = DATA;
                        end else begin
                           tx_underrun = 1'b1;
                           state_nx    = EOP;
                        end
                     end else begin
                        state_nx = EOP;
                     end
                  end else begin
                     shreg_nx   = {1'b0, shreg[7:1]};
                     bit_idx_nx = bit_idx + 3'd1;
                  end
               end
            end
         end

         EOP: begin
            eop     = 1'b1;
            sending = 1'b1;
            if (strobe) begin
               if (eop_cnt == EOP_LAST) begin
                  eop_cnt_nx = '0;
                  state_nx   = POST;
               end else begin
                  eop_cnt_nx = eop_cnt + 2'd1;
               end
            end
         end

         POST: begin
            if (strobe) begin
               state_nx = IDLE;
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // The strobe must coincide with the final count of the bit period.
   strobe_at_last_count: assert property (
      @(posedge clk) disable iff (rst)
      shift_enable |-> (clk_cnt == CNT_W'(CLKS_PER_BIT - 1))
   );

endmodule

// File: tb/tb_usb_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_serializer
// Table-driven bench for usb_tx_serializer with CLKS_PER_BIT=8, plus directed
// sequences for mid-packet reset and back-to-back packets.
// -----------------------------------------------------------------------------
module tb_usb_tx_serializer;

   localparam int unsigned CPB = 8;

   logic clk = 1'b0;
   logic rst;
   logic d_orig, shift_enable, eop, sending, busy, tx_underrun;

   usb_tx_serializer_if bus ();

   usb_tx_serializer #(
      .CLKS_PER_BIT (CPB),
      .SYNC_BYTE    (8'h80),
      .STUFF_LIMIT  (6)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .tx           (bus.slave),
      .d_orig       (d_orig),
      .shift_enable (shift_enable),
      .eop          (eop),
      .sending      (sending),
      .busy         (busy),
      .tx_underrun  (tx_underrun)
   );

   always #5 clk = ~clk;

   // One packet: inputs (bytes, how many are offered) and expected response.
   // exp_bits bit k-1 = d_orig on strobe k for the n_data SYNC/DATA strobes.
   typedef struct {
      string       name;
      int          n_bytes;
      int          n_offer;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [31:0] exp_bits;
      int          n_data;
      logic [31:0] exp_ready;
      logic [31:0] exp_under;
   } vec_t;

   vec_t vecs [6];

   int checks   = 0;
   int failures = 0;

   logic [63:0] cap_d, cap_eop, cap_send, cap_ready, cap_under;
   int n_strobes, busy_cycles, under_pulses, ready_pulses;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_sending"}, 64'(sending), 64'd0);
      check({tag, "_eop"}, 64'(eop), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_d_orig"}, 64'(d_orig), 64'd1);
      check({tag, "_shift_en"}, 64'(shift_enable), 64'd0);
      check({tag, "_tx_ready"}, 64'(bus.tx_ready), 64'd0);
      check({tag, "_underrun"}, 64'(tx_underrun), 64'd0);
   endtask

   // Drives one packet and records outputs on every strobe. Stops when busy
   // falls after having risen, or early at strobe abort_strobe (if nonzero).
   task automatic run_packet(input vec_t v, input int abort_strobe, output bit done);
      int  idx     = 0;
      bit  started = 0;
      cap_d = '0; cap_eop = '0; cap_send = '0; cap_ready = '0; cap_under = '0;
      n_strobes = 0; busy_cycles = 0; under_pulses = 0; ready_pulses = 0;
      done = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         if (idx < v.n_offer) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = (idx == 0) ? v.b0 : v.b1;
            bus.tx_last  = (idx == v.n_bytes - 1);
         end else begin
            bus.tx_valid = 1'b0;
            bus.tx_data  = '0;
            bus.tx_last  = 1'b0;
         end
         #1;
         if (busy) begin
            started = 1'b1;
            busy_cycles++;
         end else if (started) begin
            done = 1'b1;
            break;
         end
         if (tx_underrun) under_pulses++;
         if (bus.tx_ready) ready_pulses++;
         if (shift_enable) begin
            if (n_strobes < 64) begin
               cap_d[n_strobes]     = d_orig;
               cap_eop[n_strobes]   = eop;
               cap_send[n_strobes]  = sending;
               cap_ready[n_strobes] = bus.tx_ready;
               cap_under[n_strobes] = tx_underrun;
            end
            n_strobes++;
            if (abort_strobe != 0 && n_strobes == abort_strobe) begin
               done = 1'b1;
               break;
            end
         end
         if (bus.tx_valid && bus.tx_ready) idx++;
      end
   endtask

   task automatic check_vec(input vec_t v);
      logic [63:0] mn;
      mn = (64'd1 << v.n_data) - 64'd1;
      check({v.name, "_bits"}, cap_d & mn, 64'(v.exp_bits) & mn);
      check({v.name, "_eop"}, cap_eop, 64'd3 << v.n_data);
      check({v.name, "_sending"}, cap_send, (64'd1 << (v.n_data + 2)) - 64'd1);
      check({v.name, "_strobes"}, 64'(n_strobes), 64'(v.n_data + 3));
      check({v.name, "_ready_at"}, cap_ready, 64'(v.exp_ready));
      check({v.name, "_under_at"}, cap_under, 64'(v.exp_under));
      check({v.name, "_ready_cnt"}, 64'(ready_pulses), 64'($countones(v.exp_ready)));
      check({v.name, "_under_cnt"}, 64'(under_pulses), 64'($countones(v.exp_under)));
      check({v.name, "_busy_cycles"}, 64'(busy_cycles), 64'((v.n_data + 3) * CPB));
   endtask

   task automatic back_to_back();
      int         hi = 0, gap = 0, phase = 0, k = 0;
      logic [7:0] sync2 = '0;
      bit         send_ok = 1'b1;
      bit         drained = 1'b0;
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'hA5;
      bus.tx_last  = 1'b1;
      for (int cyc = 0; cyc < 3000 && phase < 4; cyc++) begin
         @(negedge clk);
         #1;
         if (phase == 0) begin
            if (busy) begin hi = 1; phase = 1; end
         end else if (phase == 1) begin
            if (busy) hi++;
            else begin gap = 1; phase = 2; end
         end else if (phase == 2) begin
            if (!busy) gap++;
            else phase = 3;
         end
         if (phase == 3 && shift_enable) begin
            sync2[k] = d_orig;
            if (!sending) send_ok = 1'b0;
            k++;
            if (k == 8) phase = 4;
         end
      end
      check("b2b_reached_sync2", 64'(phase), 64'd4);
      check("b2b_first_busy_cycles", 64'(hi), 64'(19 * CPB));
      check("b2b_idle_gap", 64'(gap), 64'd1);
      check("b2b_sync2_bits", 64'(sync2), 64'h80);
      check("b2b_sync2_sending", 64'(send_ok), 64'd1);
      // Second packet consumed A5 on its SYNC handshake; let it finish.
      @(negedge clk);
      bus.tx_valid = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         #1;
         if (!busy) begin drained = 1'b1; break; end
      end
      check("b2b_second_done", 64'(drained), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit done;

      //            name          nb no  b0     b1     exp_bits      n   ready        under
      vecs[0] = '{"a5_single",   1, 1, 8'hA5, 8'h00, 32'h0000A580, 16, 32'h00000080, 32'h00000000};
      vecs[1] = '{"ff_stuff",    1, 1, 8'hFF, 8'h00, 32'h0001DF80, 17, 32'h00000080, 32'h00000000};
      vecs[2] = '{"3f_c0",       2, 2, 8'h3F, 8'hC0, 32'h01805F80, 25, 32'h00010080, 32'h00000000};
      vecs[3] = '{"underrun",    2, 1, 8'h12, 8'h00, 32'h00001280, 16, 32'h00000080, 32'h00008000};
      vecs[4] = '{"fc_end_stuff",1, 1, 8'hFC, 8'h00, 32'h0000FC80, 17, 32'h00000080, 32'h00000000};
      vecs[5] = '{"fc_01_stuffrdy",2, 2, 8'hFC, 8'h01, 32'h0002FC80, 25, 32'h00010080, 32'h00000000};

      rst          = 1'b1;
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;
      bus.tx_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check_idle_outputs("idle_no_valid");

      for (int i = 0; i < 6; i++) begin
         run_packet(vecs[i], 0, done);
         check({vecs[i].name, "_finished"}, 64'(done), 64'd1);
         check_vec(vecs[i]);
         repeat (3) @(negedge clk);
      end

      // Reset in the middle of DATA aborts without EOP.
      run_packet(vecs[0], 11, done);
      check("midrst_reached_data", 64'(done), 64'd1);
      rst          = 1'b1;
      bus.tx_valid = 1'b0;
      @(posedge clk);
      #1;
      check_idle_outputs("midrst");
      rst = 1'b0;
      run_packet(vecs[0], 0, done);
      check("after_rst_finished", 64'(done), 64'd1);
      check_vec(vecs[0]);

      back_to_back();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
